elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
Consumer end of the elevator request queue. Reads the head entry maintained by queue_logic and drives the car toward that level one level at a time, with a travel timer per level. On arrival it opens the door for a fixed time and pulses `arrived`. queue_logic uses that pulse, together with `pos_lvl`, to remove the served level from the queue.

Parameters:
- LEVELS, 4, number of floors; legal levels are 0..LEVELS-1 (A=0, B=1, C=2, D=3).
- LVL_W, 2, level field width; must satisfy 2^LVL_W >= LEVELS.
- TRAVEL_CYCLES, 8, clock cycles to move one level; must be >= 1.
- DOOR_CYCLES, 16, clock cycles the door stays open; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- queue_empty  in  1  1 when the queue tail is 0, i.e. there is no pending request.
- queue_head  in  LVL_W  level at queue position 0; valid only when queue_empty=0.
- pos_lvl  out  LVL_W  current car level; feeds queue_logic.pos_lvl.
- arrived  out  1  one-cycle pulse when the door opens at pos_lvl; consumed by queue_logic.
- moving_up  out  1  car is travelling upward.
- moving_down  out  1  car is travelling downward.
- door_open  out  1  door is open.
- busy  out  1  state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: pos_lvl=0, all single-bit outputs 0, state=IDLE, timer=0. A reset asserted mid-travel or mid-door returns immediately to these values on the next edge. No partial level is retained.
- States: IDLE, UP, DOWN, DOOR.
- Target level is `queue_head`, sampled live. If queue_head >= LEVELS, it is clamped to LEVELS-1.
- IDLE behaviour:
  - queue_empty=1: stay in IDLE.
  - target == pos_lvl: go to DOOR, assert arrived for that same cycle.
  - target > pos_lvl: go to UP, load timer with TRAVEL_CYCLES-1.
  - target < pos_lvl: go to DOWN, load timer with TRAVEL_CYCLES-1.
- UP/DOWN behaviour:
  - moving_up or moving_down is held at 1 for the whole state.
  - Timer decrements each cycle. When the timer is 0, pos_lvl is incremented or decremented on that edge.
  - Target is re-evaluated only at level boundaries (timer==0), compared against the new pos_lvl:
    - Equal: go to DOOR with an arrived pulse.
    - Same direction still needed: reload timer, stay in state.
    - Opposite direction needed: switch UP<->DOWN and reload timer.
    - queue_empty=1: go to IDLE.
  - Latency from IDLE to reaching a level k floors away: k*TRAVEL_CYCLES cycles.
- Range guard: pos_lvl never exceeds LEVELS-1 and never goes below 0. A boundary with no legal move forces IDLE.
- DOOR behaviour:
  - arrived=1 only on the first DOOR cycle. door_open=1 for exactly DOOR_CYCLES cycles, then IDLE.
  - queue_head and queue_empty are ignored while in DOOR.
- Requests for the current level that arrive during DOOR get no second pulse until the state is IDLE again. That request is served on the next IDLE evaluation, giving a fresh DOOR cycle.
- moving_up, moving_down and door_open are mutually exclusive. busy = (state != IDLE).

Optional Feature:
- Macro: ELEVATOR_DOOR_HOLD_EN.
- When defined:
  - Adds input port `door_hold` (1 bit).
  - While in DOOR with door_hold=1, the door timer reloads to DOOR_CYCLES-1, so the door stays open indefinitely.
  - The door closes DOOR_CYCLES cycles after door_hold falls.
  - arrived is still pulsed only once per DOOR entry.
- When undefined: there is no door_hold port and the door time is fixed.

Test Plan:
- Reset, then queue_empty=1 for 50 cycles -> pos_lvl=0, busy=0, arrived never pulses.
- From pos_lvl=0, queue_head=3, queue_empty=0 (defaults) ->
  - moving_up=1, and pos_lvl steps 1,2,3 at cycles 8, 16, 24 after leaving IDLE.
  - arrived pulses once with pos_lvl=3.
  - door_open=1 for 16 cycles, then IDLE.
- At pos_lvl=2, queue_head=2 -> DOOR entered on the next edge with arrived=1 and no motion.
- At pos_lvl=3 heading to head=0, head changes to 2 mid-segment ->
  - Car completes the step to pos_lvl=2.
  - Car enters DOOR there with arrived=1.
- Mid-UP from 0 toward 3 at cycle 4, queue_empty goes 1 -> pos_lvl becomes 1 at cycle 8, then IDLE, no arrived pulse.
- Reset asserted during DOOR at pos_lvl=3 -> next edge gives pos_lvl=0 and all outputs 0.
- With ELEVATOR_DOOR_HOLD_EN: door_hold=1 for 40 cycles in DOOR ->
  - door_open stays 1 for those 40 cycles plus 16 more.
  - Exactly one arrived pulse.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: steps the car toward the queue head one level per
// travel period, then holds the door open. Optional ELEVATOR_DOOR_HOLD_EN adds door_hold.
module elevator_car_ctrl #(
  parameter int LEVELS        = 4,
  parameter int LVL_W         = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic             door_hold,
`endif
  input  logic             queue_empty,
  input  logic [LVL_W-1:0] queue_head,
  output logic [LVL_W-1:0] pos_lvl,
  output logic             arrived,
  output logic             moving_up,
  output logic             moving_down,
  output logic             door_open,
  output logic             busy
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    TRAVEL_RELOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]    DOOR_RELOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [LVL_W-1:0] MAX_LVL       = LVL_W'(LEVELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LVL_W-1:0] pos_q, pos_d;
  logic             arrived_q, arrived_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             door_q, door_d;
  logic             busy_q, busy_d;

  logic [LVL_W-1:0] target;
  logic             boundary;
  logic [LVL_W-1:0] step_pos;

  // Out-of-range requests are treated as the top floor.
  assign target = (int'(queue_head) > LEVELS - 1) ? MAX_LVL : queue_head;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pos_d     = pos_q;
    arrived_d = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    door_d    = 1'b0;
    boundary  = 1'b0;
    step_pos  = pos_q;

    case (state_q)
      S_IDLE: begin
        if (!queue_empty) begin
          if (target == pos_q) begin
            state_d   = S_DOOR;
            timer_d   = DOOR_RELOAD;
            arrived_d = 1'b1;
            door_d    = 1'b1;
          end else if (target > pos_q) begin
            state_d = S_UP;
            timer_d = TRAVEL_RELOAD;
            up_d    = 1'b1;
          end else begin
            state_d = S_DOWN;
            timer_d = TRAVEL_RELOAD;
            down_d  = 1'b1;
          end
        end
      end
      S_UP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
          up_d    = 1'b1;
        end else if (pos_q == MAX_LVL) begin
          state_d = S_IDLE;
        end else begin
          boundary = 1'b1;
          step_pos = pos_q + LVL_W'(1);
        end
      end
      S_DOWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
          down_d  = 1'b1;
        end else if (pos_q == '0) begin
          state_d = S_IDLE;
        end else begin
          boundary = 1'b1;
          step_pos = pos_q - LVL_W'(1);
        end
      end
      default: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
          door_d  = 1'b1;
        end
`ifdef ELEVATOR_DOOR_HOLD_EN
        if (door_hold) begin
          state_d = S_DOOR;
          timer_d = DOOR_RELOAD;
          door_d  = 1'b1;
        end
`endif
      end
    endcase

    // The target is only re-examined once a full level has been travelled.
    if (boundary) begin
      pos_d = step_pos;
      if (queue_empty) begin
        state_d = S_IDLE;
      end else if (target == step_pos) begin
        state_d   = S_DOOR;
        timer_d   = DOOR_RELOAD;
        arrived_d = 1'b1;
        door_d    = 1'b1;
      end else if (target > step_pos) begin
        state_d = S_UP;
        timer_d = TRAVEL_RELOAD;
        up_d    = 1'b1;
      end else begin
        state_d = S_DOWN;
        timer_d = TRAVEL_RELOAD;
        down_d  = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pos_q     <= '0;
      arrived_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pos_q     <= pos_d;
      arrived_q <= arrived_d;
      up_q      <= up_d;
      down_q    <= down_d;
      door_q    <= door_d;
      busy_q    <= busy_d;
    end
  end

  assign pos_lvl     = pos_q;
  assign arrived     = arrived_q;
  assign moving_up   = up_q;
  assign moving_down = down_q;
  assign door_open   = door_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl: arrival pulses are scored against
// a queue of expected (level, cycle) pairs pushed when each request is driven.
module tb_elevator_car_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       queue_empty;
  logic [1:0] queue_head;
  logic [1:0] pos_lvl;
  logic       arrived;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic       busy;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold;
`endif

  elevator_car_ctrl #(
    .LEVELS(4), .LVL_W(2), .TRAVEL_CYCLES(8), .DOOR_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .queue_empty(queue_empty),
    .queue_head(queue_head),
    .pos_lvl(pos_lvl),
    .arrived(arrived),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lvl;
    int at;
  } arr_t;

  arr_t sb[$];
  arr_t mon_e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_arrival(input int lvl, input int at);
    arr_t e;
    e.lvl = lvl;
    e.at  = at;
    sb.push_back(e);
    $display("txn: expect arrival at level %0d on cycle %0d", lvl, at);
  endtask

  // Scoreboard side: every arrived pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (arrived === 1'b1) begin
      if (sb.size() == 0) begin
        check("arr_unexpected", 32'(arrived), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("txn: arrival at level %0d on cycle %0d", pos_lvl, cyc);
        check("arr_lvl", 32'(pos_lvl), 32'(mon_e.lvl));
        check("arr_cyc", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int l;
    int bad;
    reset       = 1'b1;
    queue_empty = 1'b1;
    queue_head  = 2'd0;
`ifdef ELEVATOR_DOOR_HOLD_EN
    door_hold   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_pos",  32'(pos_lvl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_up",   32'(moving_up), 32'd0);
    check("rst_dn",   32'(moving_down), 32'd0);
    check("rst_arr",  32'(arrived), 32'd0);
    reset = 1'b0;

    // Empty queue: the car must stay parked.
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || pos_lvl !== 2'd0 || arrived !== 1'b0) bad++;
    end
    check("idle_50", 32'(bad), 32'd0);

    // 0 -> 3 upward run.
    k = cyc; queue_head = 2'd3; queue_empty = 1'b0; l = k + 1;
    expect_arrival(3, l + 24);
    goto(l);      check("up_start", 32'(moving_up), 32'd1);
                  check("up_busy", 32'(busy), 32'd1);
    goto(l + 7);  check("up_pos7", 32'(pos_lvl), 32'd0);
    goto(l + 8);  check("up_pos8", 32'(pos_lvl), 32'd1);
    goto(l + 16); check("up_pos16", 32'(pos_lvl), 32'd2);
    goto(l + 23); check("up_mov23", 32'(moving_up), 32'd1);
    goto(l + 24); check("up_pos24", 32'(pos_lvl), 32'd3);
                  check("up_door24", 32'(door_open), 32'd1);
                  check("up_mov24", 32'(moving_up), 32'd0);
    queue_empty = 1'b1;
    goto(l + 39); check("door_last", 32'(door_open), 32'd1);
    goto(l + 40); check("door_closed", 32'(door_open), 32'd0);
                  check("door_idle", 32'(busy), 32'd0);

    // Head changes from 0 to 2 while moving down from 3.
    k = cyc; queue_head = 2'd0; queue_empty = 1'b0; l = k + 1;
    expect_arrival(2, l + 8);
    goto(l);      check("dn_start", 32'(moving_down), 32'd1);
    goto(l + 3);  queue_head = 2'd2;
    goto(l + 8);  check("dn_pos", 32'(pos_lvl), 32'd2);
                  check("dn_door", 32'(door_open), 32'd1);
                  check("dn_mov", 32'(moving_down), 32'd0);
    queue_empty = 1'b1;
    goto(l + 24); check("dn_idle", 32'(busy), 32'd0);

    // Request at current level, kept pending through the door: second door after IDLE.
    k = cyc; queue_head = 2'd2; queue_empty = 1'b0; l = k + 1;
    expect_arrival(2, l);
    expect_arrival(2, l + 17);
    goto(l);      check("same_door", 32'(door_open), 32'd1);
                  check("same_move", 32'(moving_up | moving_down), 32'd0);
    goto(l + 16); check("same_idle", 32'(busy), 32'd0);
    goto(l + 17); check("same_door2", 32'(door_open), 32'd1);
    queue_empty = 1'b1;
    goto(l + 33); check("same_idle2", 32'(busy), 32'd0);

    // 2 -> 3, then reset in the middle of the door.
    k = cyc; queue_head = 2'd3; queue_empty = 1'b0; l = k + 1;
    expect_arrival(3, l + 8);
    goto(l + 8);  check("r_pos", 32'(pos_lvl), 32'd3);
    queue_empty = 1'b1;
    goto(l + 10); reset = 1'b1;
    goto(l + 11); check("rd_pos",  32'(pos_lvl), 32'd0);
                  check("rd_door", 32'(door_open), 32'd0);
                  check("rd_busy", 32'(busy), 32'd0);
                  check("rd_arr",  32'(arrived), 32'd0);
    reset = 1'b0;

    // Queue empties mid-segment: finish the step, then IDLE with no arrival.
    goto(l + 12);
    k = cyc; queue_head = 2'd3; queue_empty = 1'b0; l = k + 1;
    goto(l + 3);  queue_empty = 1'b1;
    goto(l + 7);  check("e_pos7", 32'(pos_lvl), 32'd0);
                  check("e_mov7", 32'(moving_up), 32'd1);
    goto(l + 8);  check("e_pos8", 32'(pos_lvl), 32'd1);
                  check("e_busy8", 32'(busy), 32'd0);
                  check("e_mov8", 32'(moving_up), 32'd0);
    goto(l + 12); check("e_stay", 32'(pos_lvl), 32'd1);

`ifdef ELEVATOR_DOOR_HOLD_EN
    k = cyc; queue_head = 2'd1; queue_empty = 1'b0; door_hold = 1'b1; l = k + 1;
    expect_arrival(1, l);
    goto(l);      queue_empty = 1'b1;
    goto(l + 40); check("hold_door40", 32'(door_open), 32'd1);
    door_hold = 1'b0;
    goto(l + 55); check("hold_door55", 32'(door_open), 32'd1);
    goto(l + 56); check("hold_closed", 32'(door_open), 32'd0);
                  check("hold_idle", 32'(busy), 32'd0);
`endif

    goto(cyc + 3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
